// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory-stage sequencer.
//   op_e    : request opcodes seen on req_op
//   state_e : one state per sequence step, plus StIdle
//   ctrl_t  : registered memory-stage control bundle
//   Asel*/Wsel* : memory address / write-source select encodings
//   decode_ctrl() maps a step state to its controls; first_step() maps an op to its entry state.
package mem_seq_pkg;

    localparam logic [1:0] AselSp    = 2'b00;
    localparam logic [1:0] AselLdd   = 2'b01;
    localparam logic [1:0] AselStd   = 2'b10;

    localparam logic [1:0] WselReg   = 2'b00;
    localparam logic [1:0] WselPcLo  = 2'b01;
    localparam logic [1:0] WselPcHi  = 2'b10;
    localparam logic [1:0] WselFlags = 2'b11;

    typedef enum logic [2:0] {
        OpLoad  = 3'b000,
        OpStore = 3'b001,
        OpPush  = 3'b010,
        OpPop   = 3'b011,
        OpCall  = 3'b100,
        OpRet   = 3'b101,
        OpRti   = 3'b110,
        OpNop   = 3'b111
    } op_e;

    typedef enum logic [3:0] {
        StIdle, StLd, StSt, StPsh, StPop, StCallHi, StCallLo, StRetLo,
        StRetHi, StRtiFl, StRtiLo, StRtiHi, StIntHi, StIntLo, StIntFl, StNop
    } state_e;

    typedef struct packed {
        logic       read;
        logic       write;
        logic       push;
        logic       pop;
        logic [1:0] asel;
        logic [1:0] wsel;
        logic       done;
        logic       int_ack;
    } ctrl_t;

    function automatic state_e first_step(input op_e op);
        case (op)
            OpLoad:  return StLd;
            OpStore: return StSt;
            OpPush:  return StPsh;
            OpPop:   return StPop;
            OpCall:  return StCallHi;
            OpRet:   return StRetLo;
            OpRti:   return StRtiFl;
            default: return StNop;
        endcase
    endfunction

    // Interrupt entry is not an accepted request, so its last step carries no done.
    function automatic ctrl_t decode_ctrl(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            StLd:     begin c.read = 1'b1; c.asel = AselLdd; c.done = 1'b1; end
            StSt:     begin c.write = 1'b1; c.asel = AselStd; c.wsel = WselReg; c.done = 1'b1; end
            StPsh:    begin c.push = 1'b1; c.asel = AselSp; c.wsel = WselReg; c.done = 1'b1; end
            StPop:    begin c.pop = 1'b1; c.asel = AselSp; c.done = 1'b1; end
            StCallHi: begin c.push = 1'b1; c.wsel = WselPcHi; end
            StCallLo: begin c.push = 1'b1; c.wsel = WselPcLo; c.done = 1'b1; end
            StRetLo:  c.pop = 1'b1;
            StRetHi:  begin c.pop = 1'b1; c.done = 1'b1; end
            StRtiFl:  c.pop = 1'b1;
            StRtiLo:  c.pop = 1'b1;
            StRtiHi:  begin c.pop = 1'b1; c.done = 1'b1; end
            StIntHi:  begin c.push = 1'b1; c.wsel = WselPcHi; c.int_ack = 1'b1; end
            StIntLo:  begin c.push = 1'b1; c.wsel = WselPcLo; end
            StIntFl:  begin c.push = 1'b1; c.wsel = WselFlags; end
            StNop:    c.done = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/memory_sequencer.sv
// Memory-stage micro-sequencer: expands LOAD/STORE/PUSH/POP/CALL/RET/RTI requests and
// interrupt entry into one-cycle memory steps.
//   clk, reset (async, active-high)
//   req_valid/req_op/req_ready : request handshake, accept = req_valid & req_ready
//   int_req/int_ack            : interrupt request pulse / service acknowledge
//   stall                      : ~req_ready
//   memory_read/write/push/pop, memory_address_select, memory_write_src_select : step controls
//   done                       : last step of an accepted sequence
//   load_we/pc_lo_we/pc_hi_we/flags_we : data_r capture strobes, one cycle after the step
module memory_sequencer
    import mem_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_op,
    output logic       req_ready,
    input  logic       int_req,
    output logic       int_ack,
    output logic       stall,
    output logic       memory_read,
    output logic       memory_write,
    output logic       memory_push,
    output logic       memory_pop,
    output logic [1:0] memory_address_select,
    output logic [1:0] memory_write_src_select,
    output logic       done,
    output logic       load_we,
    output logic       pc_lo_we,
    output logic       pc_hi_we,
    output logic       flags_we
);

    state_e r_state;
    ctrl_t  r_ctrl;
    logic   r_int_pending;
    logic   r_load_we;
    logic   r_pc_lo_we;
    logic   r_pc_hi_we;
    logic   r_flags_we;

    state_e w_state_next;
    ctrl_t  w_ctrl_next;
    logic   w_enter_int;
    logic   w_accept;

    always_comb begin
        w_enter_int  = (r_state == StIdle) && r_int_pending;
        w_accept     = req_valid && req_ready;
        w_state_next = StIdle;
        case (r_state)
            StIdle: begin
                if (w_enter_int) begin
                    w_state_next = StIntHi;
                end else if (w_accept) begin
                    w_state_next = first_step(op_e'(req_op));
                end else begin
                    w_state_next = StIdle;
                end
            end
            StCallHi: w_state_next = StCallLo;
            StRetLo:  w_state_next = StRetHi;
            StRtiFl:  w_state_next = StRtiLo;
            StRtiLo:  w_state_next = StRtiHi;
            StIntHi:  w_state_next = StIntLo;
            StIntLo:  w_state_next = StIntFl;
            default:  w_state_next = StIdle;
        endcase
        // Controls are registered alongside the state they belong to.
        w_ctrl_next = decode_ctrl(w_state_next);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_ctrl        <= '0;
            r_int_pending <= 1'b0;
            r_load_we     <= 1'b0;
            r_pc_lo_we    <= 1'b0;
            r_pc_hi_we    <= 1'b0;
            r_flags_we    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= w_ctrl_next;
            // Clear on service entry wins so a pulse pending at entry is served only once.
            if (w_enter_int) begin
                r_int_pending <= 1'b0;
            end else if (int_req) begin
                r_int_pending <= 1'b1;
            end
            // Popped data lands in data_r one cycle after the pop step.
            r_load_we  <= (r_state == StLd) || (r_state == StPop);
            r_pc_lo_we <= (r_state == StRetLo) || (r_state == StRtiLo);
            r_pc_hi_we <= (r_state == StRetHi) || (r_state == StRtiHi);
            r_flags_we <= (r_state == StRtiFl);
        end
    end

    assign req_ready               = (r_state == StIdle) && !r_int_pending;
    assign stall                   = !req_ready;
    assign memory_read             = r_ctrl.read;
    assign memory_write            = r_ctrl.write;
    assign memory_push             = r_ctrl.push;
    assign memory_pop              = r_ctrl.pop;
    assign memory_address_select   = r_ctrl.asel;
    assign memory_write_src_select = r_ctrl.wsel;
    assign done                    = r_ctrl.done;
    assign int_ack                 = r_ctrl.int_ack;
    assign load_we                 = r_load_we;
    assign pc_lo_we                = r_pc_lo_we;
    assign pc_hi_we                = r_pc_hi_we;
    assign flags_we                = r_flags_we;

endmodule
